// File: rtl/snake_tile_renderer_if.sv
// Bundle of timing-generator inputs, CPU tile/palette write strobes and VGA
// pixel outputs for the snake tile renderer.
interface snake_tile_renderer_if;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        blank_in;
    logic        frame_end;
    logic        tile_we;
    logic [10:0] tile_addr;
    logic [3:0]  tile_wdata;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [11:0] pal_wdata;
    logic [11:0] rgb;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        blank_out;
    logic [15:0] frame_cnt;

    modport master (
        output h_cnt, v_cnt, h_sync_in, v_sync_in, blank_in, frame_end,
        output tile_we, tile_addr, tile_wdata, pal_we, pal_addr, pal_wdata,
        input  rgb, h_sync_out, v_sync_out, blank_out, frame_cnt
    );

    modport slave (
        input  h_cnt, v_cnt, h_sync_in, v_sync_in, blank_in, frame_end,
        input  tile_we, tile_addr, tile_wdata, pal_we, pal_addr, pal_wdata,
        output rgb, h_sync_out, v_sync_out, blank_out, frame_cnt
    );
endinterface

// File: rtl/snake_tile_renderer.sv
// 3-stage pixel colour pipeline: tile RAM lookup -> frame-synchronous palette -> RGB444.
// Optional grid-line overlay enabled by defining SNAKE_GRID_LINES_EN.
module snake_tile_renderer #(
    parameter int unsigned TILE_COLS  = 40,
    parameter int unsigned TILE_ROWS  = 30,
    parameter int unsigned TILE_BITS  = 4,
    parameter logic [11:0] GRID_COLOR = 12'h222
) (
    input  logic                 clk,
    input  logic                 rst,
    snake_tile_renderer_if.slave bus
);
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned TILE_CNT = TILE_COLS * TILE_ROWS;
    localparam int unsigned PAL_N    = 2 ** TILE_BITS;
    localparam int unsigned RGB_W    = 12;
    localparam int unsigned FCNT_W   = 16;

    logic [TILE_BITS-1:0] tile_ram [TILE_CNT];
    logic [RGB_W-1:0]     pal_shadow [PAL_N];
    logic [RGB_W-1:0]     pal_active [PAL_N];

    logic [5:0]           row_c;
    logic [6:0]           col_c;
    logic [ADDR_W-1:0]    rd_addr_c;
    logic [ADDR_W-1:0]    tile_rd_addr;
    logic [TILE_BITS-1:0] tile_q;
    logic [1:0]           hs_d;
    logic [1:0]           vs_d;
    logic [1:0]           bl_d;
    logic [RGB_W-1:0]     rgb_c;
    logic [RGB_W-1:0]     rgb_q;
    logic                 hs_q;
    logic                 vs_q;
    logic                 bl_q;
    logic [FCNT_W-1:0]    frame_cnt_q;

    // Tile index row*40 + col, with *40 built from two shifts.
    assign row_c     = bus.v_cnt[9:4];
    assign col_c     = bus.h_cnt[10:4];
    assign rd_addr_c = (ADDR_W'(row_c) << 5) + (ADDR_W'(row_c) << 3) + ADDR_W'(col_c);

    // Write port of the tile RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.tile_we && (bus.tile_addr < ADDR_W'(TILE_CNT))) begin
            tile_ram[bus.tile_addr] <= bus.tile_wdata;
        end
    end

    // S1 address register and S2 read register (read-first against the write port).
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_rd_addr <= '0;
            tile_q       <= '0;
        end else begin
            tile_rd_addr <= rd_addr_c;
            tile_q       <= tile_ram[tile_rd_addr];
        end
    end

    // Shadow palette takes CPU writes; active copy updates only at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PAL_N); i++) begin
                pal_shadow[TILE_BITS'(i)] <= '0;
                pal_active[TILE_BITS'(i)] <= '0;
            end
        end else begin
            if (bus.frame_end) begin
                for (int i = 0; i < int'(PAL_N); i++) begin
                    pal_active[TILE_BITS'(i)] <= pal_shadow[TILE_BITS'(i)];
                end
            end
            if (bus.pal_we) begin
                pal_shadow[bus.pal_addr] <= bus.pal_wdata;
            end
        end
    end

`ifdef SNAKE_GRID_LINES_EN
    logic grid_d1;
    logic grid_d2;

    always_ff @(posedge clk) begin
        if (rst) begin
            grid_d1 <= 1'b0;
            grid_d2 <= 1'b0;
        end else begin
            grid_d1 <= (bus.h_cnt[3:0] == 4'd0) | (bus.v_cnt[3:0] == 4'd0);
            grid_d2 <= grid_d1;
        end
    end
`else
    logic unused_c;
    assign unused_c = ^{bus.h_cnt[3:0], bus.v_cnt[3:0], GRID_COLOR};
`endif

    // S3 colour select; blanking always wins.
    always_comb begin
        rgb_c = pal_active[tile_q];
`ifdef SNAKE_GRID_LINES_EN
        if (grid_d2 && (tile_q == '0)) begin
            rgb_c = GRID_COLOR;
        end
`endif
        if (bl_d[1]) begin
            rgb_c = '0;
        end
    end

    // Sync/blank delay line matched to the colour pipeline, plus output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_d        <= 2'b11;
            vs_d        <= 2'b00;
            bl_d        <= 2'b11;
            hs_q        <= 1'b1;
            vs_q        <= 1'b0;
            bl_q        <= 1'b1;
            rgb_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            hs_d  <= {hs_d[0], bus.h_sync_in};
            vs_d  <= {vs_d[0], bus.v_sync_in};
            bl_d  <= {bl_d[0], bus.blank_in};
            hs_q  <= hs_d[1];
            vs_q  <= vs_d[1];
            bl_q  <= bl_d[1];
            rgb_q <= rgb_c;
            if (bus.frame_end) begin
                frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
            end
        end
    end

    assign bus.rgb        = rgb_q;
    assign bus.h_sync_out = hs_q;
    assign bus.v_sync_out = vs_q;
    assign bus.blank_out  = bl_q;
    assign bus.frame_cnt  = frame_cnt_q;

endmodule
